// File: rtl/sid_env_pkg.sv
// Shared types, register map and rate/period tables for the multi-voice SID envelope.
package sid_env_pkg;

    typedef enum logic [1:0] {
        ATT     = 2'd0,
        DEC_SUS = 2'd1,
        REL     = 2'd2
    } stage_e;

    typedef enum logic [1:0] {
        SW_IDLE = 2'd0,
        SW_RUN  = 2'd1,
        SW_DONE = 2'd2
    } sweep_e;

    localparam int unsigned CNT_W = 15;
    localparam int unsigned DIV_W = 5;

    localparam int unsigned VOICE_STRIDE = 7;
    localparam int unsigned OFS_CTRL     = 4;
    localparam int unsigned OFS_AD       = 5;
    localparam int unsigned OFS_SR       = 6;

    // Lower bound of each exponential range, paired with its step period.
    localparam logic [7:0] EXP_TH_1  = 8'h5E;
    localparam logic [7:0] EXP_TH_2  = 8'h37;
    localparam logic [7:0] EXP_TH_4  = 8'h1B;
    localparam logic [7:0] EXP_TH_8  = 8'h0F;
    localparam logic [7:0] EXP_TH_16 = 8'h07;
    localparam logic [7:0] EXP_TH_30 = 8'h01;

    typedef struct packed {
        logic [7:0]       env;
        stage_e           stage;
        logic             last_gate;
        logic [CNT_W-1:0] cnt;
        logic [DIV_W-1:0] exp_div;
    } voice_state_t;

    typedef struct packed {
        logic       gate;
        logic [3:0] att;
        logic [3:0] dec;
        logic [3:0] sus;
        logic [3:0] rel;
    } voice_regs_t;

    localparam voice_state_t VOICE_STATE_RST = '{
        env: 8'h00, stage: REL, last_gate: 1'b0, cnt: '0, exp_div: '0
    };
    localparam voice_regs_t VOICE_REGS_RST = '0;

    function automatic logic [CNT_W-1:0] cnt_max(input logic [3:0] rate);
        logic [CNT_W-1:0] m;
        case (rate)
            4'd0:    m = 15'd8;
            4'd1:    m = 15'd31;
            4'd2:    m = 15'd62;
            4'd3:    m = 15'd94;
            4'd4:    m = 15'd148;
            4'd5:    m = 15'd219;
            4'd6:    m = 15'd266;
            4'd7:    m = 15'd312;
            4'd8:    m = 15'd391;
            4'd9:    m = 15'd976;
            4'd10:   m = 15'd1953;
            4'd11:   m = 15'd3125;
            4'd12:   m = 15'd3906;
            4'd13:   m = 15'd11719;
            4'd14:   m = 15'd19531;
            default: m = 15'd31250;
        endcase
        return m;
    endfunction

    function automatic logic [DIV_W-1:0] exp_period(input logic [7:0] env);
        logic [DIV_W-1:0] p;
        if (env >= EXP_TH_1)       p = 5'd1;
        else if (env >= EXP_TH_2)  p = 5'd2;
        else if (env >= EXP_TH_4)  p = 5'd4;
        else if (env >= EXP_TH_8)  p = 5'd8;
        else if (env >= EXP_TH_16) p = 5'd16;
        else if (env >= EXP_TH_30) p = 5'd30;
        else                       p = 5'd1;
        return p;
    endfunction

endpackage

// File: rtl/sid_env_mux_if.sv
// Register bus, tick input and envelope outputs of the multi-voice envelope block.
interface sid_env_mux_if #(
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned ADDR_W     = 5
);
    logic                    clkEn;
    logic                    iWE;
    logic [ADDR_W-1:0]       iAddr;
    logic [7:0]              iData;
    logic [8*NUM_VOICES-1:0] oOut;
    logic [2*NUM_VOICES-1:0] oStage;
    logic                    oValid;
    logic                    oOverrun;

    modport master (
        output clkEn, iWE, iAddr, iData,
        input  oOut, oStage, oValid, oOverrun
    );

    modport slave (
        input  clkEn, iWE, iAddr, iData,
        output oOut, oStage, oValid, oOverrun
    );
endinterface

// File: rtl/sid_env_step.sv
// Combinational next-state function for one envelope voice: gate edges, rate
// counter, linear attack and range-based exponential decay/release.
module sid_env_step
    import sid_env_pkg::*;
(
    input  voice_regs_t  regs_i,
    input  voice_state_t state_i,
    output voice_state_t state_o
);

    stage_e     stage_g;
    logic [3:0] rate;
    logic       rate_tick;
    logic [7:0] sus_lvl;
    logic [7:0] env_up;

    assign sus_lvl = {regs_i.sus, regs_i.sus};
    assign env_up  = (state_i.env == 8'hFF) ? 8'hFF : state_i.env + 8'd1;

    always_comb begin
        // NOTE: every output and local takes a default first, so no path can infer a latch.
        state_o           = state_i;
        state_o.last_gate = regs_i.gate;

        case (state_i.stage)
            ATT, DEC_SUS: stage_g = state_i.stage;
            default:      stage_g = REL;
        endcase
        if (regs_i.gate && !state_i.last_gate)      stage_g = ATT;
        else if (!regs_i.gate && state_i.last_gate) stage_g = REL;
        state_o.stage = stage_g;

        case (stage_g)
            ATT:     rate = regs_i.att;
            DEC_SUS: rate = regs_i.dec;
            default: rate = regs_i.rel;
        endcase

        rate_tick   = (state_i.cnt == '0);
        state_o.cnt = rate_tick ? cnt_max(rate) : state_i.cnt - CNT_W'(1);

        if (rate_tick) begin
            if (stage_g == ATT) begin
                state_o.env = env_up;
                if (env_up == 8'hFF) state_o.stage = DEC_SUS;
            end else if (state_i.exp_div == '0) begin
                state_o.exp_div = exp_period(state_i.env) - DIV_W'(1);
                // Decay never climbs back up if sustain is raised above env.
                if (stage_g == DEC_SUS) begin
                    if (state_i.env > sus_lvl) state_o.env = state_i.env - 8'd1;
                end else if (state_i.env != 8'h00) begin
                    state_o.env = state_i.env - 8'd1;
                end
            end else begin
                state_o.exp_div = state_i.exp_div - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/sid_env_mux.sv
// Multi-voice ADSR envelope: one shared step datapath swept across per-voice
// state, one voice per clk, started by each 1 MHz tick.
module sid_env_mux
    import sid_env_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned ADDR_W     = 5
) (
    input logic          clk,
    input logic          rst_n,
    sid_env_mux_if.slave bus
);

    localparam int unsigned       VIDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [VIDX_W-1:0] LAST_VOICE = VIDX_W'(NUM_VOICES - 1);

    sweep_e            sweep_q, sweep_d;
    logic [VIDX_W-1:0] voice_q, voice_d;
    logic              overrun_q, overrun_d;
    logic              slot_en;
    logic              valid;

    voice_regs_t  regs_q  [NUM_VOICES];
    voice_state_t state_q [NUM_VOICES];
    voice_regs_t  cur_regs;
    voice_state_t cur_state;
    voice_state_t nxt_state;

    function automatic logic [ADDR_W-1:0] voice_addr(input int unsigned v, input int unsigned ofs);
        return ADDR_W'(BASE_ADDR + VOICE_STRIDE * v + ofs);
    endfunction

    // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_q   <= SW_IDLE;
            voice_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            sweep_q   <= sweep_d;
            voice_q   <= voice_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        sweep_d = sweep_q;
        voice_d = voice_q;
        case (sweep_q)
            SW_RUN: begin
                if (voice_q == LAST_VOICE) sweep_d = SW_DONE;
                else                       voice_d = voice_q + VIDX_W'(1);
            end
            default: begin
                sweep_d = SW_IDLE;
                if (bus.clkEn) begin
                    sweep_d = SW_RUN;
                    voice_d = '0;
                end
            end
        endcase
    end

    // A tick arriving while voices are still being swept is lost.
    always_comb begin
        slot_en   = (sweep_q == SW_RUN);
        valid     = (sweep_q == SW_DONE);
        overrun_d = overrun_q | (bus.clkEn && (sweep_q == SW_RUN));
    end

    assign cur_regs  = regs_q[voice_q];
    assign cur_state = state_q[voice_q];

    sid_env_step u_step (
        .regs_i  (cur_regs),
        .state_i (cur_state),
        .state_o (nxt_state)
    );

    // A write landing on the active slot's edge is seen on the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) regs_q[v] <= VOICE_REGS_RST;
        end else if (bus.iWE) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                if (bus.iAddr == voice_addr(v, OFS_CTRL)) begin
                    regs_q[v].gate <= bus.iData[0];
                end
                if (bus.iAddr == voice_addr(v, OFS_AD)) begin
                    regs_q[v].att <= bus.iData[7:4];
                    regs_q[v].dec <= bus.iData[3:0];
                end
                if (bus.iAddr == voice_addr(v, OFS_SR)) begin
                    regs_q[v].sus <= bus.iData[7:4];
                    regs_q[v].rel <= bus.iData[3:0];
                end
            end
        end
    end

    // NOTE: the per-voice state array is reset in full; a stale env would be audible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) state_q[v] <= VOICE_STATE_RST;
        end else if (slot_en) begin
            state_q[voice_q] <= nxt_state;
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
        assign bus.oOut[8*v +: 8]   = state_q[v].env;
        assign bus.oStage[2*v +: 2] = state_q[v].stage;
    end

    assign bus.oValid   = valid;
    assign bus.oOverrun = overrun_q;

endmodule

// File: doc/sid_env_mux.md
Name: sid_env_mux

Overview:
- Multi-voice ADSR envelope generator, successor to the single-voice SID envelope.
- Serves NUM_VOICES voices by time-multiplexing one shared update datapath over per-voice state registers.
- Sits on the SID register bus (iWE/iAddr/iData) and feeds per-voice 8-bit envelope values to the voice amplitude multipliers.
- Adds behaviour the single-voice block lacks: gate edge detection, range-based exponential decay, a sweep-complete strobe and overrun detection.

Parameters:
- NUM_VOICES, 3, number of envelope channels (1..8).
- BASE_ADDR, 0, register address of voice 0 (voice v base = BASE_ADDR + 7*v).
- ADDR_W, 5, address bus width.

Ports:
- clk  in  1  master clock.
- rst_n  in  1  asynchronous, active-low reset.
- clkEn  in  1  1 MHz tick, one clk wide.
- iWE  in  1  register write enable.
- iAddr  in  ADDR_W  register address.
- iData  in  8  write data.
- oOut  out  8*NUM_VOICES  packed envelopes; voice v at [8v+7:8v].
- oStage  out  2*NUM_VOICES  packed stage per voice: 0=ATT, 1=DEC_SUS, 2=REL.
- oValid  out  1  one-cycle pulse; all voices updated for the current tick.
- oOverrun  out  1  sticky; a tick was dropped.

Behaviour:
- Reset: clock and reset are fixed as clk and rst_n, reset asynchronous active-low. Asserting rst_n low clears everything, including mid-sweep:
  - all env = 0, stage = REL, lastGate = 0;
  - rate counters = 0, exp dividers = 0;
  - all registers = 0;
  - oValid = 0, oOverrun = 0.
- Registers: per voice v, offset +4 bit0 = gate; +5 = {att[7:4], dec[3:0]}; +6 = {sus[7:4], rel[3:0]}. Writes to other addresses are ignored.
- Sweep:
  - clkEn while idle starts a sweep. Voice index runs 0..NUM_VOICES-1, one voice per clk: read state, compute, write back.
  - oValid pulses the cycle after voice N-1 is written back, so latency from clkEn to oValid is NUM_VOICES+1 clk.
  - clkEn during a sweep is dropped and sets oOverrun. oOverrun clears only on reset.
- Write collision: a register write in the same cycle as that voice's slot takes effect on the next tick. The slot uses the old value.
- Gate, sampled at the voice's slot:
  - rising edge (gate=1, lastGate=0): stage -> ATT;
  - falling edge: stage -> REL;
  - the rate counter is not reset on either edge;
  - lastGate <= gate.
- Rate counter (15 bit), rate selected by stage (att/dec/rel):
  - if cnt==0: cnt <= cntMax(rate) and rateTick=1;
  - else: cnt decrements.
- ATT:
  - on rateTick, env+1;
  - when the increment produces 0xFF, stage -> DEC_SUS in the same update.
  - no exponential division in attack.
- DEC_SUS and REL, on rateTick:
  - if expDiv==0: expDiv <= period(env)-1, then step env;
  - else: expDiv decrements.
- period(env) by range:
  - 0x5E–0xFF: 1
  - 0x37–0x5D: 2
  - 0x1B–0x36: 4
  - 0x0F–0x1A: 8
  - 0x07–0x0E: 16
  - 0x01–0x06: 30
  - 0x00: 1
- Step rules:
  - DEC_SUS: env-1 only while env > {sus,sus}; env never rises if sustain is raised.
  - REL: env-1, clamped at 0x00.
- Illegal stage encoding (3) -> REL.
- All env arithmetic is 8-bit unsigned and saturating; no wrap at either end.

Decomposition:
- Package sid_env_pkg:
  - stage enum (ATT/DEC_SUS/REL);
  - 16-entry cntMax table: 8,31,62,94,148,219,266,312,391,976,1953,3125,3906,11719,19531,31250;
  - exp-period range thresholds and periods;
  - register offsets 4/5/6 and voice stride 7.
- Sub-module sid_env_step: combinational per-voice next-state function.
  - Inputs: gate, att/dec/sus/rel, env, stage, lastGate, cnt, expDiv.
  - Outputs: the next values of the same state.
- Top level holds the register file, state arrays, sweep counter and strobes.

Test Plan:
- Reset mid-sweep (rst_n low while voice 1 is in its slot) -> all oOut=0, oStage all REL, oValid=0 on the next clk; no spurious oValid after release.
- Voice 0: att=0, gate 0->1, then clkEn ticks -> env=0x01 after tick 1, +1 every 9 ticks, 0xFF at tick 2287, oStage0=DEC_SUS in the same update.
- Voice 1: from 0xFF, dec=0, sus=0xA -> env decays and holds at 0xAA. Raising sus to 0xF leaves env at 0xAA; lowering sus to 0x5 resumes decay to 0x55.
- Voice 2: release from 0x06, rel=0 -> steps every 30*9=270 ticks, reaches 0x00, stays 0x00 with no underflow.
- NUM_VOICES=3: clkEn two clk after the previous clkEn -> oOverrun=1 (sticky), that tick dropped, oValid still 4 clk after the accepted tick.
- Write to BASE+7+4 in voice 1's slot cycle -> gate change seen at the next tick, not the current one; voices 0 and 2 are unaffected.
